// File: rtl/fp_exec_pipe_ctrl_pkg.sv
// Shared types for the FP execution-stage control pipeline.
// Holds stage-register layout and the wrap-around flush-range check.
package fp_exec_pipe_ctrl_pkg;

    localparam int unsigned FP_EXEC_LATENCY = 4;
    localparam int unsigned AL_INDEX_WIDTH  = 6;
    localparam int unsigned PREG_WIDTH      = 7;

    typedef logic [AL_INDEX_WIDTH-1:0] ALIndex;
    typedef logic [PREG_WIDTH-1:0]     PRegNum;

    typedef struct packed {
        logic   valid;
        ALIndex tag;
        PRegNum dst;
        logic   writesReg;
    } FPExecCtrlStage;

    // Tags wrap, so distances from head are compared modulo 2^AL_INDEX_WIDTH.
    function automatic logic IsInFlushRange(ALIndex t, ALIndex head, ALIndex tail);
        ALIndex off;
        ALIndex len;
        off = t - head;
        len = tail - head;
        return off < len;
    endfunction

endpackage

// File: rtl/fp_exec_pipe_ctrl_lane.sv
// One FP lane: shift chain of stage registers with kill filtering,
// wakeup/writeback taps and a live-op counter.
module fp_exec_lane_ctrl
    import fp_exec_pipe_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = FP_EXEC_LATENCY,
    parameter int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             flushAll,
    input  ALIndex           flushHead,
    input  ALIndex           flushTail,
    input  logic             inValid,
    input  ALIndex           inTag,
    input  PRegNum           inDst,
    input  logic             inWritesReg,
    output logic             wakeupValid,
    output PRegNum           wakeupDst,
    output logic             wbValid,
    output ALIndex           wbTag,
    output PRegNum           wbDst,
    output logic             wbWritesReg,
    output logic [CNT_W-1:0] inFlight
);

    localparam int unsigned WK = LATENCY - 2;
    localparam int unsigned WB = LATENCY - 1;

    FPExecCtrlStage   stage_q [LATENCY];
    FPExecCtrlStage   stage_d [LATENCY];
    logic [CNT_W-1:0] inFlight_q;
    logic [CNT_W-1:0] inFlight_d;
    logic             killIn;

    always_comb begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i];
            if (flushAll || (flush && IsInFlushRange(stage_q[i].tag, flushHead, flushTail))) begin
                stage_d[i].valid = 1'b0;
            end
        end
        killIn = flushAll || (flush && IsInFlushRange(inTag, flushHead, flushTail));
        // The last stage is overwritten on advance, so a retiring op is never re-checked.
        if (!stall) begin
            for (int unsigned i = LATENCY - 1; i > 0; i--) begin
                stage_d[i] = stage_d[i-1];
            end
            stage_d[0] = '{valid: inValid && !killIn, tag: inTag, dst: inDst, writesReg: inWritesReg};
        end
        inFlight_d = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inFlight_d = inFlight_d + CNT_W'(stage_d[i].valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            inFlight_q <= '0;
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            inFlight_q <= inFlight_d;
        end
    end

    assign wakeupValid = stage_q[WK].valid && stage_q[WK].writesReg;
    assign wakeupDst   = stage_q[WK].valid ? stage_q[WK].dst : '0;
    assign wbValid     = stage_q[WB].valid;
    assign wbTag       = stage_q[WB].valid ? stage_q[WB].tag : '0;
    assign wbDst       = stage_q[WB].valid ? stage_q[WB].dst : '0;
    assign wbWritesReg = stage_q[WB].valid && stage_q[WB].writesReg;
    assign inFlight    = inFlight_q;

endmodule

// File: rtl/fp_exec_pipe_ctrl.sv
// FP execution-stage control pipeline: one independent control chain per
// FP issue lane, shadowing the fixed-latency datapath.
module fp_exec_pipe_ctrl #(
    parameter int unsigned FP_ISSUE_WIDTH  = 2,
    parameter int unsigned FP_EXEC_LATENCY = fp_exec_pipe_ctrl_pkg::FP_EXEC_LATENCY,
    parameter int unsigned AL_INDEX_WIDTH  = fp_exec_pipe_ctrl_pkg::AL_INDEX_WIDTH,
    parameter int unsigned PREG_WIDTH      = fp_exec_pipe_ctrl_pkg::PREG_WIDTH
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         stall,
    input  logic [FP_ISSUE_WIDTH-1:0]                                    inValid,
    input  logic [FP_ISSUE_WIDTH-1:0][AL_INDEX_WIDTH-1:0]                inTag,
    input  logic [FP_ISSUE_WIDTH-1:0][PREG_WIDTH-1:0]                    inDst,
    input  logic [FP_ISSUE_WIDTH-1:0]                                    inWritesReg,
    input  logic                                                         flush,
    input  logic                                                         flushAll,
    input  logic [AL_INDEX_WIDTH-1:0]                                    flushHead,
    input  logic [AL_INDEX_WIDTH-1:0]                                    flushTail,
    output logic [FP_ISSUE_WIDTH-1:0]                                    wakeupValid,
    output logic [FP_ISSUE_WIDTH-1:0][PREG_WIDTH-1:0]                    wakeupDst,
    output logic [FP_ISSUE_WIDTH-1:0]                                    wbValid,
    output logic [FP_ISSUE_WIDTH-1:0][AL_INDEX_WIDTH-1:0]                wbTag,
    output logic [FP_ISSUE_WIDTH-1:0][PREG_WIDTH-1:0]                    wbDst,
    output logic [FP_ISSUE_WIDTH-1:0]                                    wbWritesReg,
    output logic [FP_ISSUE_WIDTH-1:0][$clog2(FP_EXEC_LATENCY+1)-1:0]     inFlight
);

    for (genvar l = 0; l < FP_ISSUE_WIDTH; l++) begin : g_lane
        fp_exec_lane_ctrl #(
            .LATENCY (FP_EXEC_LATENCY)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .stall       (stall),
            .flush       (flush),
            .flushAll    (flushAll),
            .flushHead   (flushHead),
            .flushTail   (flushTail),
            .inValid     (inValid[l]),
            .inTag       (inTag[l]),
            .inDst       (inDst[l]),
            .inWritesReg (inWritesReg[l]),
            .wakeupValid (wakeupValid[l]),
            .wakeupDst   (wakeupDst[l]),
            .wbValid     (wbValid[l]),
            .wbTag       (wbTag[l]),
            .wbDst       (wbDst[l]),
            .wbWritesReg (wbWritesReg[l]),
            .inFlight    (inFlight[l])
        );
    end

endmodule

// File: tb/tb_fp_exec_pipe_ctrl.sv
// Bench for fp_exec_pipe_ctrl: age-based op model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fp_exec_pipe_ctrl;

    localparam int NL = 2;
    localparam int L  = 4;
    localparam int AW = 6;
    localparam int PW = 7;
    localparam int CW = $clog2(L + 1);

    logic                   clk, rst, stall, flush, flushAll;
    logic [AW-1:0]          flushHead, flushTail;
    logic [NL-1:0]          inValid, inWritesReg, wakeupValid, wbValid, wbWritesReg;
    logic [NL-1:0][AW-1:0]  inTag, wbTag;
    logic [NL-1:0][PW-1:0]  inDst, wakeupDst, wbDst;
    logic [NL-1:0][CW-1:0]  inFlight;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int tag; int dst; bit wr; int age; } op_t;
    typedef struct { int lane; int tag; int cyc; } wb_t;
    op_t mq [NL][$];
    wb_t wlog[$];

    fp_exec_pipe_ctrl #(
        .FP_ISSUE_WIDTH  (NL),
        .FP_EXEC_LATENCY (L),
        .AL_INDEX_WIDTH  (AW),
        .PREG_WIDTH      (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .inValid     (inValid),
        .inTag       (inTag),
        .inDst       (inDst),
        .inWritesReg (inWritesReg),
        .flush       (flush),
        .flushAll    (flushAll),
        .flushHead   (flushHead),
        .flushTail   (flushTail),
        .wakeupValid (wakeupValid),
        .wakeupDst   (wakeupDst),
        .wbValid     (wbValid),
        .wbTag       (wbTag),
        .wbDst       (wbDst),
        .wbWritesReg (wbWritesReg),
        .inFlight    (inFlight)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic bit mkill(int t);
        int m;
        m = 1 << AW;
        if (flushAll) return 1;
        if (!flush) return 0;
        return ((t - int'(flushHead) + m) % m) < ((int'(flushTail) - int'(flushHead) + m) % m);
    endfunction

    // Model: each live op carries its age (stages advanced through).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NL; l++) mq[l].delete();
        end else begin
            for (int l = 0; l < NL; l++) begin
                op_t nq[$];
                op_t o;
                nq.delete();
                for (int i = 0; i < mq[l].size(); i++) begin
                    o = mq[l][i];
                    if (!stall && o.age == L) continue;
                    if (mkill(o.tag)) continue;
                    if (!stall) o.age++;
                    nq.push_back(o);
                end
                if (!stall && inValid[l] && !mkill(int'(inTag[l]))) begin
                    o.tag = int'(inTag[l]);
                    o.dst = int'(inDst[l]);
                    o.wr  = inWritesReg[l];
                    o.age = 1;
                    nq.push_back(o);
                end
                mq[l] = nq;
            end
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            bit ewk, ehas, ewb, ewbw, bad;
            int ewkd, ewbt, ewbd;
            ewk = 0; ehas = 0; ewb = 0; ewbw = 0; ewkd = 0; ewbt = 0; ewbd = 0;
            for (int i = 0; i < mq[l].size(); i++) begin
                if (mq[l][i].age == L - 1) begin
                    ehas = 1; ewk = mq[l][i].wr; ewkd = mq[l][i].dst;
                end
                if (mq[l][i].age == L) begin
                    ewb = 1; ewbt = mq[l][i].tag; ewbd = mq[l][i].dst; ewbw = mq[l][i].wr;
                end
            end
            bad = (wakeupValid[l] !== ewk) || (wbValid[l] !== ewb) ||
                  (wbTag[l] !== AW'(ewbt)) || (wbDst[l] !== PW'(ewbd)) ||
                  (wbWritesReg[l] !== ewbw) || (inFlight[l] !== CW'(mq[l].size()));
            if ((ewk || !ehas) && wakeupDst[l] !== PW'(ewkd)) bad = 1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL model lane%0d cyc%0d: got wk=%0b/%0d wb=%0b/%0d/%0d/%0b infl=%0d; want wk=%0b/%0d wb=%0b/%0d/%0d/%0b infl=%0d",
                         l, cyc, wakeupValid[l], wakeupDst[l], wbValid[l], wbTag[l], wbDst[l], wbWritesReg[l], inFlight[l],
                         ewk, ewkd, ewb, ewbt, ewbd, ewbw, mq[l].size());
            end
            if (!rst && !stall && wbValid[l]) wlog.push_back('{lane: l, tag: int'(wbTag[l]), cyc: cyc});
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        inValid = '0; inTag = '0; inDst = '0; inWritesReg = '0;
        stall = 0; flush = 0; flushAll = 0; flushHead = '0; flushTail = '0;
    endtask

    task automatic put(input int l, input int tag, input int dst, input bit wr);
        inValid[l] = 1'b1;
        inTag[l] = AW'(tag);
        inDst[l] = PW'(dst);
        inWritesReg[l] = wr;
    endtask

    function automatic int lane_count(input int l);
        int n = 0;
        foreach (wlog[i]) if (wlog[i].lane == l) n++;
        return n;
    endfunction

    initial begin
        int a0;
        wb_t e[$];
        rst = 1;
        clr_in();
        repeat (2) step();
        chk("rst_wbValid", int'(wbValid), 0);
        chk("rst_wakeupValid", int'(wakeupValid), 0);
        chk("rst_inFlight", int'(inFlight), 0);
        rst = 0;
        step();

        // Single op on lane 0
        put(0, 5, 12, 1);
        step();
        clr_in();
        chk("single_if_c0", int'(inFlight[0]), 1);
        step();
        chk("single_if_c1", int'(inFlight[0]), 1);
        chk("single_wk_c1", int'(wakeupValid[0]), 0);
        step();
        chk("single_wk_c2", int'(wakeupValid[0]), 1);
        chk("single_wkdst_c2", int'(wakeupDst[0]), 12);
        chk("single_wb_c2", int'(wbValid[0]), 0);
        chk("single_if_c2", int'(inFlight[0]), 1);
        step();
        chk("single_wb_c3", int'(wbValid[0]), 1);
        chk("single_wbtag_c3", int'(wbTag[0]), 5);
        chk("single_wbdst_c3", int'(wbDst[0]), 12);
        chk("single_wk_c3", int'(wakeupValid[0]), 0);
        chk("single_if_c3", int'(inFlight[0]), 1);
        step();
        chk("single_wb_c4", int'(wbValid[0]), 0);
        chk("single_if_c4", int'(inFlight[0]), 0);

        // Back-to-back on both lanes
        wlog.delete();
        a0 = 0;
        for (int i = 0; i < 8; i++) begin
            put(0, i, i, 1);
            put(1, 32 + i, 40 + i, i[0]);
            step();
            if (i == 0) a0 = cyc;
            if (i == 3 || i == 7) begin
                chk("b2b_sat0", int'(inFlight[0]), 4);
                chk("b2b_sat1", int'(inFlight[1]), 4);
            end
        end
        clr_in();
        repeat (6) step();
        chk("b2b_count0", lane_count(0), 8);
        chk("b2b_count1", lane_count(1), 8);
        e.delete();
        foreach (wlog[i]) if (wlog[i].lane == 0) e.push_back(wlog[i]);
        for (int k = 0; k < e.size() && k < 8; k++) begin
            chk("b2b_tag", e[k].tag, k);
            chk("b2b_cyc", e[k].cyc, a0 + 3 + k);
        end

        // Stall for two cycles after one op
        wlog.delete();
        put(0, 3, 30, 1);
        step();
        a0 = cyc;
        clr_in();
        step();
        stall = 1;
        put(0, 9, 31, 1);
        step();
        step();
        clr_in();
        repeat (5) step();
        chk("stall_count", lane_count(0), 1);
        if (wlog.size() > 0) begin
            chk("stall_tag", wlog[0].tag, 3);
            chk("stall_cyc", wlog[0].cyc, a0 + 5);
        end

        // Wrap-around selective flush while holding
        wlog.delete();
        put(0, 62, 1, 1); step();
        put(0, 63, 2, 1); step();
        put(0, 0, 3, 1);  step();
        put(0, 1, 4, 1);  step();
        clr_in();
        chk("wrap_if_before", int'(inFlight[0]), 4);
        flush = 1; flushHead = 6'd63; flushTail = 6'd1; stall = 1;
        step();
        clr_in();
        chk("wrap_if_after", int'(inFlight[0]), 2);
        repeat (5) step();
        chk("wrap_count", lane_count(0), 2);
        if (wlog.size() == 2) begin
            chk("wrap_tag0", wlog[0].tag, 62);
            chk("wrap_tag1", wlog[1].tag, 1);
        end

        // flushAll + flush + stall + incoming op
        put(0, 10, 5, 1);
        put(1, 11, 6, 1);
        step();
        clr_in();
        flushAll = 1; flush = 1; stall = 1;
        put(0, 12, 7, 1);
        step();
        clr_in();
        chk("fa_if0", int'(inFlight[0]), 0);
        chk("fa_if1", int'(inFlight[1]), 0);
        chk("fa_wk", int'(wakeupValid), 0);
        chk("fa_wb", int'(wbValid), 0);
        wlog.delete();
        repeat (6) step();
        chk("fa_nowb", wlog.size(), 0);

        // Async reset mid-stream
        put(0, 20, 8, 1); step();
        put(0, 21, 9, 1); step();
        put(0, 22, 10, 1); step();
        clr_in();
        chk("ar_if_before", int'(inFlight[0]), 3);
        chk("ar_wk_before", int'(wakeupValid[0]), 1);
        #2 rst = 1;
        #1;
        chk("ar_wk", int'(wakeupValid), 0);
        chk("ar_wkdst", int'(wakeupDst), 0);
        chk("ar_wb", int'(wbValid), 0);
        chk("ar_wbtag", int'(wbTag), 0);
        chk("ar_if", int'(inFlight), 0);
        step();
        rst = 0;
        wlog.delete();
        repeat (8) step();
        chk("ar_nowb", wlog.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_exec_pipe_ctrl.md
# fp_exec_pipe_ctrl

Control pipeline of the FP execution stage. It accepts ops latched by the FP register-read stage, one per FP issue lane per cycle. It carries each op's tag and destination through a fixed-latency pipeline that shadows the FP datapath, and produces a wakeup one cycle before writeback plus the writeback valid/tag/destination. It also applies stalls and selective recovery flushes, so that killed ops never reach wakeup or writeback.

## Interface
Parameters:
- FP_ISSUE_WIDTH, 2, number of independent FP lanes
- FP_EXEC_LATENCY, 4, pipeline depth in cycles; must be at least 2
- AL_INDEX_WIDTH, 6, active-list pointer width in bits (wrap-around tags)
- PREG_WIDTH, 7, physical register number width in bits

Ports (per-lane signals are arrays of size FP_ISSUE_WIDTH):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold all pipeline registers
- inValid[l]  in  1  op present from the register-read stage
- inTag[l]  in  AL_INDEX_WIDTH  active-list index of the op
- inDst[l]  in  PREG_WIDTH  destination physical register
- inWritesReg[l]  in  1  op writes a register
- flush  in  1  selective recovery request
- flushAll  in  1  kill every in-flight op; has priority over the range check
- flushHead  in  AL_INDEX_WIDTH  first tag to kill
- flushTail  in  AL_INDEX_WIDTH  one past the last tag to kill
- wakeupValid[l]  out  1  stage FP_EXEC_LATENCY-1 holds a live op that writes a register
- wakeupDst[l]  out  PREG_WIDTH  destination of that op
- wbValid[l]  out  1  stage FP_EXEC_LATENCY holds a live op
- wbTag[l]  out  AL_INDEX_WIDTH  tag of the writeback op
- wbDst[l]  out  PREG_WIDTH  destination of the writeback op
- wbWritesReg[l]  out  1  writeback op writes a register
- inFlight[l]  out  clog2(FP_EXEC_LATENCY+1)  number of live ops in lane l

## Operation
- Each lane is a shift chain of FP_EXEC_LATENCY stage registers {valid, tag, dst, writesReg}. Stage 1 is loaded from the inputs.
- Kill predicate for a tag t:
  - always true if flushAll=1;
  - otherwise, with flush=1, true when ((t − flushHead) mod 2^W) < ((flushTail − flushHead) mod 2^W), where W = AL_INDEX_WIDTH;
  - flushHead==flushTail with flushAll=0 kills nothing.
- Each cycle, for every stage and for the incoming op:
  - next valid = current valid AND NOT kill(tag);
  - if stall=0, the chain advances one stage and stage 1 takes inValid AND NOT kill(inTag);
  - if stall=1, every stage keeps its contents but still clears valid on kill, and the inputs are ignored.
- The op leaving stage FP_EXEC_LATENCY (stall=0) is retired from the chain. It is not re-checked against flush.
- Outputs:
  - wakeup and wb are driven from the stage registers and gated by the registered valid.
  - Non-valid stages drive tag/dst/writesReg as 0 on the outputs.
- inFlight is a registered counter per lane:
  - +1 on an accepted input;
  - −1 on a retire;
  - minus the number of stages killed this cycle.
  - It equals the popcount of the stage valids at all times; never wraps.

## Timing
- Reset: every stage valid=0, tag/dst/writesReg=0, inFlight=0; so all outputs are 0 from reset assertion until the first accepted op.
- Latency: an op accepted at edge k (stall=0 through edge k+FP_EXEC_LATENCY-1):
  - wakeupValid=1 during cycle k+FP_EXEC_LATENCY-2 after that edge;
  - wbValid=1 exactly one cycle later, for one cycle.
- Each stall cycle adds one cycle to the latency. During a stall, wakeup/wb outputs hold their value; the consumer must not double-count them.
- Flush takes effect at the next edge. Outputs in the flush cycle itself still reflect pre-flush state.
- Simultaneous events:
  - flush with stall: kills apply and the chain holds;
  - flush with inValid: the incoming op is filtered by the same predicate;
  - flushAll with flush: flushAll wins.
- Reset mid-operation drops all in-flight ops with no writeback.
- Throughput: one op per lane per cycle, with no internal stall source.

## Structure
- Shared package (PipelineTypes/BasicTypes side): FP_EXEC_LATENCY constant, struct FPExecCtrlStage {valid, tag, dst, writesReg}, and function IsInFlushRange(t, head, tail).
- Natural sub-module: fp_exec_lane_ctrl, one lane's chain and counter, instantiated FP_ISSUE_WIDTH times.

## Test plan
All scenarios use default parameters.
- Single op, no stall: lane 0, tag 5, dst 12, writesReg 1 at edge 0.
  - wakeupValid[0]=1, wakeupDst=12 in cycle 2; wbValid[0]=1, wbTag=5, wbDst=12 in cycle 3 only.
  - inFlight[0] goes 1,1,1,1,0.
- Back-to-back on both lanes: tags 0..7 streamed every cycle.
  - wb tags appear 0..7 in order, 4 cycles later, with no gaps.
  - inFlight saturates at 4.
- Stall: inject tag 3, then stall=1 for 2 cycles in the middle.
  - wb is delayed by exactly 2 cycles and wbValid is high for exactly one non-stalled cycle.
  - Inputs offered during the stall are not captured.
- Wrap-around flush: in-flight tags 62, 63, 0, 1; flush with head=63, tail=1.
  - Only 62 and 1 reach wb.
  - inFlight drops by 2 at the next edge.
- Flush during stall, plus a same-cycle input: flushAll=1, stall=1, inValid=1.
  - Next cycle all valids are 0, inFlight=0, and no wakeup or wb ever fires.
- Async reset asserted mid-stream with 3 ops in flight.
  - All outputs go to 0 without waiting for clk.
  - No wb occurs after release.
